// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - shared constants, digit index type and digit helpers for the scan controller
package seg7_pkg;
  localparam int NUM_DIGITS = 4;
  localparam int DIGIT_W = 4;
  localparam logic [DIGIT_W-1:0] BLANK_CODE = 4'hF;

  typedef logic [1:0] digit_idx_t;

  function automatic logic [DIGIT_W-1:0] digit_of(logic [15:0] v, digit_idx_t idx);
    case (idx)
      2'd0:    return v[15:12];
      2'd1:    return v[11:8];
      2'd2:    return v[7:4];
      default: return v[3:0];
    endcase
  endfunction

  // Rightmost digit is never a leading zero so an all-zero value still shows "0".
  function automatic logic is_leading_zero(logic [15:0] v, digit_idx_t idx);
    case (idx)
      2'd0:    return v[15:12] == 4'd0;
      2'd1:    return v[15:8] == 8'd0;
      2'd2:    return v[15:4] == 12'd0;
      default: return 1'b0;
    endcase
  endfunction
endpackage

// File: rtl/seg7_scan_ctrl_if.sv
// rtl/seg7_scan_ctrl_if.sv - load/display-side signal bundle between score logic and scan controller
interface seg7_scan_ctrl_if;
  import seg7_pkg::*;

  logic                 load;
  logic [15:0]          value_bcd;
  logic                 blank_lz;
  logic                 disp_en;
  digit_idx_t           en_out;
  logic [DIGIT_W-1:0]   bcd_out;
  logic                 frame_tick;
  logic                 pending;

  modport master (
    output load, value_bcd, blank_lz, disp_en,
    input  en_out, bcd_out, frame_tick, pending
  );

  modport slave (
    input  load, value_bcd, blank_lz, disp_en,
    output en_out, bcd_out, frame_tick, pending
  );
endinterface

// File: rtl/refresh_prescaler.sv
// rtl/refresh_prescaler.sv - free-running divider marking the last cycle of each digit dwell
module refresh_prescaler #(
  parameter int REFRESH_DIV = 100000,
  parameter int CNT_W = 20
) (
  input  logic clk,
  input  logic rst_n,
  output logic dwell_end
);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(REFRESH_DIV - 1);

  logic [CNT_W-1:0] cnt;

  assign dwell_end = (cnt == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (dwell_end) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end
endmodule

// File: rtl/seg7_scan_ctrl.sv
// rtl/seg7_scan_ctrl.sv - four-digit seven-segment scan controller with frame-aligned value updates
module seg7_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int REFRESH_DIV = 100000,
  parameter int CNT_W = 20
) (
  input  logic             clk,
  input  logic             rst_n,
  seg7_scan_ctrl_if.slave  bus
);
  logic        dwell_end;
  logic        frame_end;
  digit_idx_t  digit_q;
  logic        tick_q;
  logic        pend_flag_q;
  logic [16:0] pend_q;
  logic [16:0] disp_q;
  logic        den_q;
  logic [DIGIT_W-1:0] bcd_sel;

  refresh_prescaler #(
    .REFRESH_DIV (REFRESH_DIV),
    .CNT_W       (CNT_W)
  ) u_prescaler (
    .clk       (clk),
    .rst_n     (rst_n),
    .dwell_end (dwell_end)
  );

  assign frame_end = dwell_end && (digit_q == 2'd3);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      digit_q <= 2'd0;
      tick_q  <= 1'b0;
      den_q   <= 1'b0;
    end else begin
      if (dwell_end) begin
        digit_q <= digit_q + 2'd1;
      end
      tick_q <= frame_end;
      den_q  <= bus.disp_en;
    end
  end

  // A load coinciding with frame_end goes straight to the display; otherwise it waits in pend_q.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q      <= '0;
      pend_flag_q <= 1'b0;
      disp_q      <= '0;
    end else if (frame_end) begin
      if (bus.load) begin
        disp_q <= {bus.blank_lz, bus.value_bcd};
      end else if (pend_flag_q) begin
        disp_q <= pend_q;
      end
      pend_flag_q <= 1'b0;
    end else if (bus.load) begin
      pend_q      <= {bus.blank_lz, bus.value_bcd};
      pend_flag_q <= 1'b1;
    end
  end

  always_comb begin
    bcd_sel = digit_of(disp_q[15:0], digit_q);
    if (!den_q) begin
      bcd_sel = BLANK_CODE;
    end else if (disp_q[16] && is_leading_zero(disp_q[15:0], digit_q)) begin
      bcd_sel = BLANK_CODE;
    end
  end

  assign bus.en_out     = digit_q;
  assign bus.bcd_out    = bcd_sel;
  assign bus.frame_tick = tick_q;
  assign bus.pending    = pend_flag_q;
endmodule
